fir_filter_acc_n: RTL and testbench

//  AHB-Lite slave N-tap FIR accelerator: y[n] = sum_{k<TAPS} c[k]*x[n-k], signed samples/coefs.

---
 rtl/fir_filter_acc_n.sv | 222 ++++++++++++++++++++++
 tb/tb_fir_filter_acc_n.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_acc_n.sv
// rtl/fir_filter_acc_n.sv - AHB-Lite slave N-tap FIR accelerator with one MAC per cycle
module fir_filter_acc_n #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT
);

  localparam int KW = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int PW = DATA_W + COEF_W;

  // Word offsets (HADDR[7:2]) of the register map
  localparam logic [5:0] W_CTRL   = 6'h00;
  localparam logic [5:0] W_STATUS = 6'h01;
  localparam logic [5:0] W_XN     = 6'h02;
  localparam logic [5:0] W_YN     = 6'h03;
  localparam logic [5:0] W_COEF   = 6'h10;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(64'sd2147483647);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-64'sd2147483648);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FINISH} state_t;

  // Bus data-phase capture
  logic                     dp_sel_q, dp_sel_d;
  logic                     dp_write_q, dp_write_d;
  logic [5:0]               dp_word_q, dp_word_d;

  // Datapath and control state
  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic signed [DATA_W-1:0] hist_d [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [DATA_W-1:0] xn_q, xn_d;
  logic [31:0]              yn_q, yn_d;
  logic                     auto_q, auto_d;
  logic [4:0]               shift_q, shift_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     err_q, err_d;

  // Decoded write strobes and MAC helpers
  logic                     wr_ctrl, wr_xn, wr_coef, coef_hit, go;
  logic [KW-1:0]            coef_idx;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] go_sample;

  // Only HADDR[7:2] is decoded and HWDATA is consumed per-field
  logic unused_bus;
  assign unused_bus = ^{HADDR[31:8], HADDR[1:0], HWDATA};

  assign coef_hit = (dp_word_q >= W_COEF) && (dp_word_q < (W_COEF + 6'(TAPS)));
  assign coef_idx = KW'(dp_word_q - W_COEF);
  assign wr_ctrl  = dp_sel_q && dp_write_q && (dp_word_q == W_CTRL);
  assign wr_xn    = dp_sel_q && dp_write_q && (dp_word_q == W_XN);
  assign wr_coef  = dp_sel_q && dp_write_q && coef_hit;
  assign go       = !busy_q && ((wr_ctrl && HWDATA[0]) || (wr_xn && auto_q));
  assign go_sample = wr_xn ? HWDATA[DATA_W-1:0] : xn_q;
  assign prod     = PW'(coef_q[k_q]) * PW'(hist_q[k_q]);
  assign shifted  = acc_q >>> shift_q;

  // An early YN read waits until the result lands at the FINISH edge
  assign HREADYOUT = !(dp_sel_q && !dp_write_q && (dp_word_q == W_YN) && busy_q);

  // Read mux for the current data phase; narrow fields are sign-extended
  always_comb begin
    HRDATA = '0;
    if (dp_sel_q && !dp_write_q) begin
      if (dp_word_q == W_CTRL)        HRDATA = {19'd0, shift_q, 5'd0, auto_q, 2'b00};
      else if (dp_word_q == W_STATUS) HRDATA = {28'd0, err_q, ovf_q, done_q, busy_q};
      else if (dp_word_q == W_XN)     HRDATA = 32'(xn_q);
      else if (dp_word_q == W_YN)     HRDATA = yn_q;
      else if (coef_hit)              HRDATA = 32'(coef_q[coef_idx]);
    end
  end

  // Next-state logic: bus capture, register writes, FSM and CLEAR override
  always_comb begin
    dp_sel_d   = dp_sel_q;
    dp_write_d = dp_write_q;
    dp_word_d  = dp_word_q;
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    hist_d     = hist_q;
    coef_d     = coef_q;
    xn_d       = xn_q;
    yn_d       = yn_q;
    auto_d     = auto_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    err_d      = err_q;

    if (HREADY) begin
      dp_sel_d   = HSEL;
      dp_write_d = HWRITE;
      dp_word_d  = HADDR[7:2];
    end

    // SHIFT/AUTO always accepted; START, XN and COEF are refused while busy
    if (wr_ctrl) begin
      auto_d  = HWDATA[2];
      shift_d = HWDATA[12:8];
    end
    if (busy_q && ((wr_ctrl && HWDATA[0]) || wr_xn || wr_coef)) begin
      err_d = 1'b1;
    end
    if (!busy_q && wr_xn) begin
      xn_d = HWDATA[DATA_W-1:0];
    end
    if (!busy_q && wr_coef) begin
      coef_d[coef_idx] = HWDATA[COEF_W-1:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          hist_d[0] = go_sample;
          for (int i = 1; i < TAPS; i++) hist_d[i] = hist_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(TAPS - 1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (shifted > SAT_MAX) begin
          yn_d  = 32'h7FFF_FFFF;
          ovf_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
          yn_d  = 32'h8000_0000;
          ovf_d = 1'b1;
        end else begin
          yn_d  = shifted[31:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // CLEAR beats everything, including a START in the same write
    if (wr_ctrl && HWDATA[1]) begin
      for (int i = 0; i < TAPS; i++) hist_d[i] = '0;
      acc_d   = '0;
      k_d     = '0;
      yn_d    = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_sel_q   <= 1'b0;
      dp_write_q <= 1'b0;
      dp_word_q  <= '0;
      state_q    <= ST_IDLE;
      k_q        <= '0;
      acc_q      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      xn_q       <= '0;
      yn_q       <= '0;
      auto_q     <= 1'b0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dp_sel_q   <= dp_sel_d;
      dp_write_q <= dp_write_d;
      dp_word_q  <= dp_word_d;
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      hist_q     <= hist_d;
      coef_q     <= coef_d;
      xn_q       <= xn_d;
      yn_q       <= yn_d;
      auto_q     <= auto_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fir_filter_acc_n.sv
// tb/tb_fir_filter_acc_n.sv - scoreboard bench for fir_filter_acc_n
module tb_fir_filter_acc_n;

  localparam int TAPS = 8;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  assign HREADY = HREADYOUT;

  fir_filter_acc_n #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .ACC_W(40)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  logic rd_dp  = 1'b0;

  // Monitor: compare each completed read data phase with the scoreboard head
  always @(negedge HCLK) begin
    logic new_rd;
    exp_t e;
    new_rd = HSEL && !HWRITE && HREADYOUT;
    if (rd_dp && HREADYOUT) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_read: got %h with empty scoreboard", HRDATA);
      end else begin
        e = sb.pop_front();
        if (HRDATA === e.exp) passes++;
        else $display("FAIL %s: got %h expected %h", e.name, HRDATA, e.exp);
      end
    end
    if (HREADYOUT) rd_dp = new_rd;
  end

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic push_exp(input string nm, input logic [31:0] e);
    exp_t t;
    t.name = nm;
    t.exp  = e;
    sb.push_back(t);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = {24'd0, a};
    cycles(1);
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = d;
    cycles(1);
  endtask

  // Data phase is held until HREADYOUT; stall cycles returned
  task automatic wait_dp(output int stalls);
    stalls = 0;
    while (!HREADYOUT && stalls < 50) begin
      stalls++;
      cycles(1);
    end
    if (!HREADYOUT) begin
      checks++;
      $display("FAIL stall_timeout: HREADYOUT still %b after %0d cycles", HREADYOUT, stalls);
    end
    cycles(1);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm, output int stalls);
    push_exp(nm, e);
    HSEL = 1'b1; HWRITE = 1'b0; HADDR = {24'd0, a};
    cycles(1);
    HSEL = 1'b0;
    wait_dp(stalls);
  endtask

  initial begin
    int st;
    int total;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HWDATA = '0;
    cycles(3);
    HRESET = 1'b0;
    cycles(1);

    // 1: reset values, zero wait state
    total = 0;
    rd(8'h00, 32'h0, "rst_ctrl", st);   total += st;
    rd(8'h04, 32'h0, "rst_status", st); total += st;
    rd(8'h08, 32'h0, "rst_xn", st);     total += st;
    rd(8'h0C, 32'h0, "rst_yn", st);     total += st;
    rd(8'h40, 32'h0, "rst_coef0", st);  total += st;
    rd(8'h5C, 32'h0, "rst_coef7", st);  total += st;
    check_int("rst_stalls", total, 0);

    // 2: three-tap response to 10, 20, 30
    wr(8'h40, 32'd1); wr(8'h44, 32'd2); wr(8'h48, 32'd3);
    wr(8'h08, 32'd10); wr(8'h00, 32'h1);
    cycles(TAPS + 2);
    rd(8'h04, 32'h2, "status_done", st);
    rd(8'h0C, 32'd10, "yn_10", st);
    wr(8'h08, 32'd20); wr(8'h00, 32'h1);
    rd(8'h0C, 32'd40, "yn_40", st);
    wr(8'h08, 32'd30); wr(8'h00, 32'h1);
    cycles(TAPS + 2);
    rd(8'h0C, 32'd100, "yn_100", st);
    rd(8'h44, 32'd2, "coef1_rb", st);
    rd(8'h08, 32'd30, "xn_rb", st);

    // 3: START pipelined with an immediate YN read; hist = 30,30,20,10
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = 32'h00;
    cycles(1);
    HWDATA = 32'h1; HWRITE = 1'b0; HADDR = 32'h0C;
    push_exp("yn_stalled", 32'd150);
    cycles(1);
    HSEL = 1'b0;
    wait_dp(st);
    check_int("yn_stall_cycles", st, TAPS + 1);

    // 4: CLEAR, then AUTO start by XN write of -5
    wr(8'h00, 32'h2);
    rd(8'h0C, 32'h0, "yn_after_clear", st);
    rd(8'h04, 32'h0, "status_after_clear", st);
    wr(8'h00, 32'h4);
    wr(8'h08, 32'hFFFF_FFFB);
    rd(8'h0C, 32'hFFFF_FFFB, "yn_auto_neg5", st);
    rd(8'h08, 32'hFFFF_FFFB, "xn_sext", st);
    rd(8'h00, 32'h4, "ctrl_auto", st);

    // 5: full-scale saturation, then SHIFT=4
    for (int k = 0; k < TAPS; k++) wr(8'(8'h40 + 4 * k), 32'h7FFF);
    for (int k = 0; k < TAPS; k++) begin
      wr(8'h08, 32'h7FFF);
      cycles(TAPS + 1);
    end
    rd(8'h0C, 32'h7FFF_FFFF, "yn_sat", st);
    rd(8'h04, 32'h6, "status_ovf", st);
    wr(8'h00, 32'h0401);
    rd(8'h0C, 32'h1FFF_8000, "yn_shift4", st);
    rd(8'h04, 32'h2, "status_no_ovf", st);
    rd(8'h00, 32'h0400, "ctrl_shift", st);

    // 6: XN write while busy is dropped and flags ERR
    wr(8'h00, 32'h0401);
    wr(8'h08, 32'h1234);
    rd(8'h04, 32'h9, "status_busy_err", st);
    rd(8'h0C, 32'h1FFF_8000, "yn_after_err", st);
    rd(8'h08, 32'h7FFF, "xn_unchanged", st);
    rd(8'h04, 32'hA, "status_err_sticky", st);

    // CLEAR three cycles into MAC aborts the computation
    wr(8'h00, 32'h0401);
    cycles(1);
    wr(8'h00, 32'h0402);
    rd(8'h04, 32'h0, "status_clear_mac", st);
    rd(8'h0C, 32'h0, "yn_clear_mac", st);
    check_int("yn_clear_no_stall", st, 0);
    cycles(TAPS + 2);
    rd(8'h04, 32'h0, "status_clear_late", st);

    // CLEAR+START together: no computation
    wr(8'h00, 32'h3);
    cycles(TAPS + 2);
    rd(8'h04, 32'h0, "status_clear_start", st);
    rd(8'h0C, 32'h0, "yn_clear_start", st);

    // Unmapped and out-of-range coefficient addresses; negative coef readback
    wr(8'h60, 32'h5555);
    rd(8'h60, 32'h0, "coef8_unmapped", st);
    wr(8'h5C, 32'h8000);
    rd(8'h5C, 32'hFFFF_8000, "coef7_sext", st);
    rd(8'h40, 32'h7FFF, "coef0_kept", st);

    cycles(2);
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
